// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch front end. It keeps at most one instruction-memory
//   request outstanding and hands each returned word to the decoder through
//   a registered output stage. A 1-entry skid buffer absorbs a response that
//   arrives while the decoder is stalled. Redirects squash any in-flight or
//   buffered fetch and restart fetching at the word-aligned target.
//
// Parameters
//   RESET_PC    first fetch address after reset (word aligned)
//   NOP_INSTR   word driven on instr while no live instruction is held
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   imem_req     fetch request, high only while a request is being offered
//   imem_addr    fetch address, equal to the fetch PC register
//   imem_ready   memory accepts the request on an edge with imem_req=1
//   imem_rvalid  one-cycle response strobe
//   imem_rdata   response instruction word
//   redirect     branch/jump redirect, highest priority after rst
//   redirect_pc  redirect target (low two bits ignored)
//   stall        decoder cannot take the held instruction
//   instr        registered instruction to the decoder
//   pc_out       registered address of instr
//   instr_valid  instr/pc_out hold a live instruction
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] pc_out,
  output logic        instr_valid
);

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;
  localparam logic [31:0] START_PC  = RESET_PC & WORD_MASK;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] tag_q, tag_d;
  logic        squash_q, squash_d;

  logic [31:0] skid_instr_q, skid_pc_q;
  logic [31:0] instr_p1, pc_p1;
  logic        vld_p1;

  logic        accept;
  logic        consumed;
  logic        out_load_mem;
  logic        out_load_skid;
  logic        out_clear;
  logic        skid_load;

  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = fetch_pc_q;
  assign instr       = instr_p1;
  assign pc_out      = pc_p1;
  assign instr_valid = vld_p1;

  assign accept   = (state_q == S_REQ) && imem_ready;
  assign consumed = vld_p1 && !stall;

  // Next-state and output-stage control
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    tag_d         = tag_q;
    squash_d      = squash_q;
    out_load_mem  = 1'b0;
    out_load_skid = 1'b0;
    out_clear     = 1'b0;
    skid_load     = 1'b0;

    if (redirect) begin
      // Redirect flushes the output stage and the skid buffer; an accepted
      // or outstanding request is left to complete and its response dropped.
      fetch_pc_d = redirect_pc & WORD_MASK;
      out_clear  = 1'b1;
      case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            tag_d    = fetch_pc_q;
            squash_d = 1'b1;
            state_d  = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            squash_d = 1'b0;
            state_d  = S_REQ;
          end else begin
            squash_d = 1'b1;
          end
        end
        S_FULL: begin
          state_d = S_REQ;
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
    end else begin
      case (state_q)
        S_REQ: begin
          if (accept) begin
            tag_d      = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            if (squash_q) begin
              squash_d = 1'b0;
            end else if (!vld_p1 || !stall) begin
              out_load_mem = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!stall) begin
            out_load_skid = 1'b1;
            state_d       = S_REQ;
          end
        end
        default: begin
          state_d = S_REQ;
        end
      endcase
      if (consumed && !out_load_mem && !out_load_skid) begin
        out_clear = 1'b1;
      end
    end
  end

  // Control registers and output stage (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      fetch_pc_q <= START_PC;
      squash_q   <= 1'b0;
      vld_p1     <= 1'b0;
      instr_p1   <= NOP_INSTR;
      pc_p1      <= START_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      squash_q   <= squash_d;
      if (out_load_mem) begin
        instr_p1 <= imem_rdata;
        pc_p1    <= tag_q;
        vld_p1   <= 1'b1;
      end else if (out_load_skid) begin
        instr_p1 <= skid_instr_q;
        pc_p1    <= skid_pc_q;
        vld_p1   <= 1'b1;
      end else if (out_clear) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end
    end
  end

  // Response tag and skid buffer data; occupancy is tracked by S_FULL
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    if (skid_load) begin
      skid_instr_q <= imem_rdata;
      skid_pc_q    <= tag_q;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, imem_ready, imem_rvalid, redirect, stall;
  logic [31:0] imem_rdata, redirect_pc;
  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc_out;

  // second instance: wrap-around reset PC, memory never answers
  logic        ready2 = 1'b1, rvalid2 = 1'b0, redirect2 = 1'b0, stall2 = 1'b0;
  logic [31:0] rdata2 = 32'd0, rpc2 = 32'd0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2;

  int          total = 0;
  int          bad = 0;
  int          rsp_dly = 1;
  int          mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  logic        m_acc;
  logic [31:0] m_aaddr;

  logic        mdl_en = 1'b0;
  logic [31:0] exp_pc = 32'd0;
  int          delivered = 0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = 32'd0;

  logic [47:0] stall_pat = 48'h3C11_8A40_0C63;
  logic [47:0] rdy_pat   = 48'hFFBF_F7FE_FDFF;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .stall(stall),
    .instr(instr), .pc_out(pc_out), .instr_valid(instr_valid)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst), .imem_req(req2), .imem_addr(addr2),
    .imem_ready(ready2), .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .redirect(redirect2), .redirect_pc(rpc2), .stall(stall2),
    .instr(instr2), .pc_out(pc2), .instr_valid(valid2)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'd3 + 32'h0050_0093;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // instruction memory: one response rsp_dly cycles after acceptance
  initial begin
    imem_rvalid = 1'b0;
    imem_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      m_acc   = imem_req && imem_ready && !rst;
      m_aaddr = imem_addr;
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (m_acc) begin
        chk1("one_outstanding", mem_cnt != 0, 1'b0);
        mem_cnt  = rsp_dly;
        mem_addr = m_aaddr;
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(mem_addr);
        end
      end
    end
  end

  // reference model: the decoder must see the sequential stream from the
  // last reset/redirect target, each word equal to memory at its address
  always @(negedge clk) begin
    if (mdl_en) begin
      if (!instr_valid) chk("nop_idle", instr, NOP);
      if (prev_hold) begin
        chk1("req_hold", imem_req, 1'b1);
        chk("addr_hold", imem_addr, prev_addr);
      end
      prev_hold = imem_req && !imem_ready && !rst && !redirect;
      prev_addr = imem_addr;
      if (rst) begin
        exp_pc = 32'd0;
      end else begin
        if (instr_valid && !stall) begin
          chk("dlv_pc", pc_out, exp_pc);
          chk("dlv_instr", instr, mem_word(exp_pc));
          exp_pc = exp_pc + 32'd4;
          delivered++;
        end
        if (redirect) exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    rst = 1'b1; imem_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    cyc(3);
    rst = 1'b0;
    mdl_en = 1'b1;

    // reset state and first request
    @(negedge clk);
    chk1("rst_vld", instr_valid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc_out", pc_out, 32'd0);
    chk1("rst_req", imem_req, 1'b1);
    chk("rst_addr", imem_addr, 32'd0);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    chk1("wrap_first_req", req2, 1'b1);
    cyc(1);
    @(negedge clk);
    chk1("wait_req", imem_req, 1'b0);
    chk("wrap_second_addr", addr2, 32'h0000_0000);
    chk1("wrap_second_req", req2, 1'b0);
    cyc(1);
    @(negedge clk);
    chk("first_instr", instr, 32'h0050_0093);
    chk("first_pc", pc_out, 32'd0);
    chk1("first_vld", instr_valid, 1'b1);
    chk("next_addr", imem_addr, 32'h4);
    chk1("next_req", imem_req, 1'b1);

    // stall with 0x4 held: response for 0x8 is parked
    cyc(1);
    stall = 1'b1;
    cyc(3);
    @(negedge clk);
    chk1("full_req", imem_req, 1'b0);
    chk1("full_vld", instr_valid, 1'b1);
    chk("full_pc", pc_out, 32'h4);
    chk("full_instr", instr, 32'h0050_009F);
    cyc(3);
    @(negedge clk);
    chk1("full_req_hold", imem_req, 1'b0);
    chk("full_pc_hold", pc_out, 32'h4);
    cyc(1);
    stall = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("unpark_pc", pc_out, 32'h8);
    chk("unpark_instr", instr, 32'h0050_00AB);
    chk1("unpark_vld", instr_valid, 1'b1);
    chk("unpark_addr", imem_addr, 32'hC);

    // redirect while waiting: pending response is squashed
    rsp_dly = 3;
    cyc(1);
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    cyc(1);
    redirect = 1'b0;
    @(negedge clk);
    k = 0;
    while (!imem_req && k < 10) begin
      chk1("squash_vld", instr_valid, 1'b0);
      cyc(1);
      @(negedge clk);
      k++;
    end
    chk1("redir_req", imem_req, 1'b1);
    chk("redir_addr", imem_addr, 32'h100);
    chk1("redir_vld", instr_valid, 1'b0);
    k = 0;
    while (!instr_valid && k < 20) begin
      cyc(1);
      @(negedge clk);
      k++;
    end
    chk("redir_pc_out", pc_out, 32'h100);
    chk("redir_instr", instr, 32'h0050_0393);

    // redirect in S_FULL while stalled: redirect wins, skid discarded
    rsp_dly = 1;
    cyc(1);
    stall = 1'b1;
    cyc(5);
    @(negedge clk);
    chk1("full2_vld", instr_valid, 1'b1);
    chk1("full2_req", imem_req, 1'b0);
    chk("full2_pc", pc_out, 32'h104);
    cyc(1);
    redirect = 1'b1; redirect_pc = 32'h0000_2003;
    cyc(1);
    redirect = 1'b0; stall = 1'b0;
    @(negedge clk);
    chk1("fullredir_vld", instr_valid, 1'b0);
    chk("fullredir_instr", instr, NOP);
    chk1("fullredir_req", imem_req, 1'b1);
    chk("fullredir_addr", imem_addr, 32'h2000);

    // reset mid-wait, stale response arrives, ready low for 5 cycles
    rsp_dly = 4;
    cyc(1);
    rst = 1'b1; imem_ready = 1'b0;
    cyc(1);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) rsp_dly = 2;
      chk1("stale_req", imem_req, 1'b1);
      chk("stale_addr", imem_addr, 32'd0);
      chk1("stale_vld", instr_valid, 1'b0);
      cyc(1);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    k = 0;
    while (!instr_valid && k < 20) begin
      cyc(1);
      @(negedge clk);
      k++;
    end
    chk("post_rst_pc", pc_out, 32'd0);
    chk("post_rst_instr", instr, 32'h0050_0093);

    // mixed stall / ready pattern, checked by the model every cycle
    d0 = delivered;
    for (int i = 0; i < 48; i++) begin
      cyc(1);
      stall = stall_pat[i];
      imem_ready = rdy_pat[i];
      @(negedge clk);
      rsp_dly = 1 + (i % 3);
    end
    cyc(1);
    stall = 1'b0; imem_ready = 1'b1;
    cyc(20);
    @(negedge clk);
    chk1("progress", (delivered - d0) >= 6, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of first fetch after reset; bits [1:0] SHALL be 0.
REQ-002 Parameter: NOP_INSTR, default 32'h0000_0013, value driven on instr while no valid instruction is held.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 imem_req  output  1  fetch request to instruction memory.
REQ-006 imem_addr  output  32  fetch address; stable while imem_req=1.
REQ-007 imem_ready  input  1  memory accepts the request on a rising edge where imem_req=1 and imem_ready=1.
REQ-008 imem_rvalid  input  1  response strobe, one cycle wide, at least 1 cycle after acceptance.
REQ-009 imem_rdata  input  32  instruction word, valid when imem_rvalid=1.
REQ-010 redirect  input  1  branch/jump redirect from execute.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 stall  input  1  downstream (decoder) cannot take the held instruction.
REQ-013 instr  output  32  instruction word to decoder, registered.
REQ-014 pc_out  output  32  address of instr, registered.
REQ-015 instr_valid  output  1  instr/pc_out hold a live instruction; consumed on any edge with instr_valid=1 and stall=0.

Function
REQ-016 The block SHALL allow at most one outstanding memory request.
REQ-017 States SHALL be S_REQ (imem_req=1), S_WAIT (awaiting response), S_FULL (response parked in a 1-entry skid buffer); imem_req SHALL be 1 only in S_REQ.
REQ-018 imem_addr SHALL equal the fetch PC register; on acceptance, the accepted address SHALL be latched as the response tag, fetch PC <= fetch PC + 4 (modulo 2^32; 32'hFFFF_FFFC wraps to 0), and the state SHALL become S_WAIT.
REQ-019 S_REQ with imem_ready=0: hold state, imem_req and imem_addr unchanged.
REQ-020 S_WAIT with imem_rvalid=1 and output free (instr_valid=0 or stall=0): instr <= imem_rdata, pc_out <= tag, instr_valid <= 1, go to S_REQ.
REQ-021 S_WAIT with imem_rvalid=1 and output occupied (instr_valid=1 and stall=1): skid buffer <= {imem_rdata, tag}, go to S_FULL; the response SHALL NOT be lost.
REQ-022 S_FULL with stall=0: output registers <= skid buffer, instr_valid stays 1, go to S_REQ; with stall=1, hold.
REQ-023 The output consumed with no new load that edge: instr_valid <= 0, instr <= NOP_INSTR.
REQ-024 redirect=1 SHALL take priority over stall and all other events: fetch PC <= {redirect_pc[31:2], 2'b00}, instr_valid <= 0, instr <= NOP_INSTR, skid buffer discarded.
REQ-025 redirect in S_WAIT without imem_rvalid the same cycle: set squash flag, stay S_WAIT; the next response SHALL be dropped, squash cleared, then go to S_REQ.
REQ-026 redirect in S_WAIT with imem_rvalid the same cycle, or in S_FULL: drop the response, go to S_REQ.
REQ-027 redirect in S_REQ coincident with acceptance: set squash, go to S_WAIT; without acceptance: go to S_REQ with the new address.
REQ-028 A squashed response SHALL never appear on instr or pc_out.
REQ-029 Latency: acceptance to instr_valid=1 SHALL be exactly 1 cycle after imem_rvalid when the output is free.

Reset
REQ-030 While rst=1 at a rising edge: state <= S_REQ, fetch PC <= RESET_PC, instr_valid <= 0, instr <= NOP_INSTR, pc_out <= RESET_PC, squash <= 0, skid empty; rst SHALL override redirect.
REQ-031 The first cycle after rst deasserts SHALL show imem_req=1, imem_addr=RESET_PC.
REQ-032 rst asserted while a request is outstanding: the late response SHALL be ignored (treated as squashed).

Verification
REQ-033 Reset release, imem_ready=1, rvalid 1 cycle after accept, data 32'h0050_0093 -> instr=32'h0050_0093, pc_out=0, instr_valid=1; next fetch at 0x4.
REQ-034 stall=1 held with instruction at 0x4 -> response for 0x8 parked (S_FULL), imem_req=0; stall drops -> pc_out=0x8 next cycle, no instruction lost or duplicated.
REQ-035 redirect=1, redirect_pc=32'h0000_0102 while in S_WAIT -> pending response dropped, next imem_addr=0x100, instr_valid=0 until the 0x100 response arrives.
REQ-036 RESET_PC=32'hFFFF_FFFC -> second fetch address = 32'h0000_0000.
REQ-037 rst pulsed mid-S_WAIT, stale rvalid arrives afterwards -> instr_valid stays 0, imem_addr=RESET_PC.
REQ-038 imem_ready=0 for 5 cycles -> imem_req=1 and imem_addr constant across all 5 cycles.
